// File: rtl/stack_ctrl_pkg.sv
// Shared types and default geometry for the stack sequencer.
//   stack_op_t : decoder request opcodes
//   state_t    : sequencer FSM states
//   fault_t    : sticky fault codes
package stack_ctrl_pkg;

  localparam int unsigned DW_DEF       = 16;
  localparam int unsigned AW_DEF       = 10;
  localparam int unsigned SP_TOP_DEF   = 32'h3FF;
  localparam int unsigned SP_LIMIT_DEF = 32'h300;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_PUSH = 3'd1,
    OP_POP  = 3'd2,
    OP_CALL = 3'd3,
    OP_RET  = 3'd4,
    OP_LDSP = 3'd5
  } stack_op_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_INC   = 3'd2,
    ST_READ  = 3'd3,
    ST_RESP  = 3'd4,
    ST_FAULT = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    FLT_NONE      = 2'd0,
    FLT_OVERFLOW  = 2'd1,
    FLT_UNDERFLOW = 2'd2
  } fault_t;

endpackage

// File: rtl/stack_ctrl.sv
// Stack sequencer: turns PUSH/POP/CALL/RET/LDSP requests into stack-pointer
// strobes and stack-RAM accesses. The stack grows down; SP names the next free
// slot (write-then-decrement, increment-then-read).
// Ports:
//   clk, rst                 clock, async active-high reset
//   req_*                    decoder request channel (valid/ready)
//   sp_val / sp_inc,dec,load,din  stack pointer readback and control
//   mem_*                    stack RAM port, read data one cycle after mem_re
//   rsp_*                    POP/RET result channel (valid/ready)
//   fault, fault_code, fault_clr  sticky overflow/underflow reporting
module stack_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned SP_TOP   = SP_TOP_DEF,
  parameter int unsigned SP_LIMIT = SP_LIMIT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  stack_op_t     req_op,
  input  logic [DW-1:0] req_data,
  input  logic [AW-1:0] req_pc,
  input  logic [AW-1:0] sp_val,
  output logic          sp_inc,
  output logic          sp_dec,
  output logic          sp_load,
  output logic [AW-1:0] sp_din,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic          mem_re,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_ret,
  output logic          fault,
  output fault_t        fault_code,
  input  logic          fault_clr
);

  localparam logic [AW-1:0] SP_EMPTY = AW'(SP_TOP);
  localparam logic [AW-1:0] SP_FULL  = AW'(SP_LIMIT - 1);

  state_t        state_q;
  logic [DW-1:0] word_q;
  logic          is_ret_q;
  logic [AW-1:0] mem_addr_q;
  logic          mem_we_q;
  logic          mem_re_q;
  logic          sp_inc_q;
  logic          sp_dec_q;
  logic          rsp_valid_q;
  logic [DW-1:0] rsp_data_q;
  logic          rsp_cap_q;
  logic          rsp_ret_q;
  logic          fault_q;
  fault_t        fault_code_q;
  logic          accept;

  assign req_ready = (state_q == ST_IDLE);
  assign accept    = req_valid & req_ready;

  // LDSP acts in the acceptance cycle itself, so its strobe is decoded directly
  // from the request rather than registered.
  assign sp_load = accept & (req_op == OP_LDSP);
  assign sp_din  = sp_load ? req_data[AW-1:0] : '0;

  // RAM data arrives in the first RESP cycle; it is forwarded then and held
  // from the captured copy afterwards so the result stays stable.
  assign rsp_data = (state_q == ST_RESP && !rsp_cap_q) ? mem_rdata : rsp_data_q;

  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_re     = mem_re_q;
  assign mem_wdata  = word_q;
  assign sp_inc     = sp_inc_q;
  assign sp_dec     = sp_dec_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_ret    = rsp_ret_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;

  // Sequencer FSM with registered strobes; strobes default low every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      word_q       <= '0;
      is_ret_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      sp_inc_q     <= 1'b0;
      sp_dec_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_cap_q    <= 1'b0;
      rsp_ret_q    <= 1'b0;
      fault_q      <= 1'b0;
      fault_code_q <= FLT_NONE;
    end else begin
      mem_we_q <= 1'b0;
      mem_re_q <= 1'b0;
      sp_inc_q <= 1'b0;
      sp_dec_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            case (req_op)
              OP_PUSH, OP_CALL: begin
                if (sp_val == SP_FULL) begin
                  state_q      <= ST_FAULT;
                  fault_q      <= 1'b1;
                  fault_code_q <= FLT_OVERFLOW;
                end else begin
                  word_q     <= (req_op == OP_CALL) ? DW'(req_pc) : req_data;
                  mem_addr_q <= sp_val;
                  mem_we_q   <= 1'b1;
                  sp_dec_q   <= 1'b1;
                  state_q    <= ST_WRITE;
                end
              end
              OP_POP, OP_RET: begin
                if (sp_val == SP_EMPTY) begin
                  state_q      <= ST_FAULT;
                  fault_q      <= 1'b1;
                  fault_code_q <= FLT_UNDERFLOW;
                end else begin
                  is_ret_q <= (req_op == OP_RET);
                  sp_inc_q <= 1'b1;
                  state_q  <= ST_INC;
                end
              end
              default: state_q <= ST_IDLE;
            endcase
          end
        end
        ST_WRITE: state_q <= ST_IDLE;
        ST_INC: begin
          // SP still holds the pre-increment value during this cycle.
          mem_addr_q <= AW'(sp_val + AW'(1));
          mem_re_q   <= 1'b1;
          state_q    <= ST_READ;
        end
        ST_READ: begin
          rsp_valid_q <= 1'b1;
          rsp_ret_q   <= is_ret_q;
          rsp_cap_q   <= 1'b0;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (!rsp_cap_q) begin
            rsp_data_q <= mem_rdata;
            rsp_cap_q  <= 1'b1;
          end
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_ret_q   <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        ST_FAULT: begin
          if (fault_clr) begin
            fault_q      <= 1'b0;
            fault_code_q <= FLT_NONE;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Self-checking bench for stack_ctrl with a stack-pointer model and a
// one-cycle-latency stack RAM. Results go through a scoreboard queue.
module tb_stack_ctrl;
  import stack_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  stack_op_t   req_op;
  logic [15:0] req_data;
  logic [9:0]  req_pc;
  logic [9:0]  sp_val;
  logic        sp_inc, sp_dec, sp_load;
  logic [9:0]  sp_din;
  logic [9:0]  mem_addr;
  logic        mem_we, mem_re;
  logic [15:0] mem_wdata, mem_rdata;
  logic        rsp_valid, rsp_ready, rsp_ret;
  logic [15:0] rsp_data;
  logic        fault;
  fault_t      fault_code;
  logic        fault_clr;

  int tests = 0;
  int fails = 0;
  int we_cnt = 0;

  typedef struct packed {
    logic [15:0] data;
    logic        ret;
  } exp_t;
  exp_t sb_q[$];
  exp_t exp_e;

  logic [15:0] ram [1024];

  stack_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_data(req_data), .req_pc(req_pc),
    .sp_val(sp_val), .sp_inc(sp_inc), .sp_dec(sp_dec), .sp_load(sp_load), .sp_din(sp_din),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_ret(rsp_ret),
    .fault(fault), .fault_code(fault_code), .fault_clr(fault_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stack pointer: active-low reset tied to ~rst, resets to the empty value.
  wire sp_rst_n = ~rst;
  always @(posedge clk or negedge sp_rst_n) begin
    if (!sp_rst_n)    sp_val <= 10'h3FF;
    else if (sp_load) sp_val <= sp_din;
    else if (sp_inc)  sp_val <= sp_val + 10'd1;
    else if (sp_dec)  sp_val <= sp_val - 10'd1;
  end

  // Stack RAM: read data valid the cycle after mem_re.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: strobe exclusivity, write counting, scoreboard on rsp handshake.
  always @(negedge clk) begin
    if (mem_we) we_cnt++;
    if (!rst) begin
      chk("strobe_onehot", 32'(($countones({sp_inc, sp_dec, sp_load}) > 1)), 32'd0);
      if (rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rsp_unexpected: got data %0h with empty scoreboard", rsp_data);
        end else begin
          exp_e = sb_q.pop_front();
          chk("rsp_data", 32'(rsp_data), 32'(exp_e.data));
          chk("rsp_ret", 32'(rsp_ret), 32'(exp_e.ret));
        end
      end
    end
  end

  task automatic wait_ready();
    @(negedge clk);
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    if (!req_ready) begin
      tests++;
      fails++;
      $display("FAIL req_ready_timeout: got 0 expected 1");
    end
  endtask

  // Presents one request in a cycle where req_ready is high; returns just after
  // the accepting edge, i.e. early in cycle N+1.
  task automatic send(input stack_op_t op, input logic [15:0] d, input logic [9:0] pc);
    wait_ready();
    req_valid = 1'b1;
    req_op    = op;
    req_data  = d;
    req_pc    = pc;
    if (op == OP_LDSP) begin
      #1;
      chk("ldsp_load", 32'(sp_load), 32'd1);
      chk("ldsp_din", 32'(sp_din), 32'(d[9:0]));
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = OP_NOP;
  endtask

  task automatic clear_fault();
    @(negedge clk);
    fault_clr = 1'b1;
    @(posedge clk);
    #1;
    fault_clr = 1'b0;
    @(negedge clk);
    chk("clr_fault", 32'(fault), 32'd0);
    chk("clr_code", 32'(fault_code), 32'(FLT_NONE));
    chk("clr_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int w0;
    rst = 1'b1; req_valid = 1'b0; req_op = OP_NOP; req_data = '0; req_pc = '0;
    rsp_ready = 1'b1; fault_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_strobes", 32'({sp_inc, sp_dec, sp_load, mem_we, mem_re}), 32'd0);
    chk("rst_rsp", 32'({rsp_valid, rsp_ret}), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_code", 32'(fault_code), 32'(FLT_NONE));
    chk("rst_data", 32'({rsp_data, mem_wdata}), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_sp", 32'(sp_val), 32'h3FF);
    @(negedge clk);
    rst = 1'b0;

    // PUSH A5A5 from reset
    send(OP_PUSH, 16'hA5A5, 10'h0);
    @(negedge clk);
    chk("push_we", 32'(mem_we), 32'd1);
    chk("push_addr", 32'(mem_addr), 32'h3FF);
    chk("push_dec", 32'(sp_dec), 32'd1);
    chk("push_wdata", 32'(mem_wdata), 32'hA5A5);
    chk("push_busy", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("push_sp", 32'(sp_val), 32'h3FE);
    chk("push_ready", 32'(req_ready), 32'd1);
    chk("push_we_off", 32'(mem_we), 32'd0);

    // POP it back
    sb_q.push_back('{data: 16'hA5A5, ret: 1'b0});
    send(OP_POP, 16'h0, 10'h0);
    @(negedge clk);
    chk("pop_inc", 32'(sp_inc), 32'd1);
    chk("pop_nrsp1", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("pop_re", 32'(mem_re), 32'd1);
    chk("pop_addr", 32'(mem_addr), 32'h3FF);
    chk("pop_sp", 32'(sp_val), 32'h3FF);
    chk("pop_nrsp2", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("pop_rsp", 32'(rsp_valid), 32'd1);
    chk("pop_ret", 32'(rsp_ret), 32'd0);
    @(negedge clk);
    chk("pop_idle", 32'(req_ready), 32'd1);

    // CALL / RET
    send(OP_CALL, 16'hFFFF, 10'h123);
    wait_ready();
    sb_q.push_back('{data: 16'h0123, ret: 1'b1});
    send(OP_RET, 16'h0, 10'h0);
    wait_ready();
    chk("ret_sp", 32'(sp_val), 32'h3FF);

    // Underflow
    send(OP_POP, 16'h0, 10'h0);
    @(negedge clk);
    chk("unf_fault", 32'(fault), 32'd1);
    chk("unf_code", 32'(fault_code), 32'(FLT_UNDERFLOW));
    chk("unf_ready", 32'(req_ready), 32'd0);
    chk("unf_inc", 32'(sp_inc), 32'd0);
    repeat (2) @(negedge clk);
    chk("unf_hold", 32'(fault), 32'd1);
    chk("unf_sp", 32'(sp_val), 32'h3FF);
    clear_fault();

    // Overflow after LDSP below the limit
    send(OP_LDSP, 16'h02FF, 10'h0);
    @(negedge clk);
    chk("ldsp_sp", 32'(sp_val), 32'h2FF);
    w0 = we_cnt;
    send(OP_PUSH, 16'h1111, 10'h0);
    @(negedge clk);
    chk("ovf_fault", 32'(fault), 32'd1);
    chk("ovf_code", 32'(fault_code), 32'(FLT_OVERFLOW));
    chk("ovf_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    chk("ovf_no_write", 32'(we_cnt - w0), 32'd0);
    chk("ovf_sp", 32'(sp_val), 32'h2FF);
    clear_fault();

    // Last usable slot
    send(OP_LDSP, 16'h0300, 10'h0);
    @(negedge clk);
    chk("ldsp300_sp", 32'(sp_val), 32'h300);
    send(OP_PUSH, 16'hBEEF, 10'h0);
    @(negedge clk);
    chk("lim_we", 32'(mem_we), 32'd1);
    chk("lim_addr", 32'(mem_addr), 32'h300);
    @(negedge clk);
    chk("lim_sp", 32'(sp_val), 32'h2FF);
    chk("lim_fault", 32'(fault), 32'd0);
    sb_q.push_back('{data: 16'hBEEF, ret: 1'b0});
    send(OP_POP, 16'h0, 10'h0);
    wait_ready();
    chk("lim_pop_sp", 32'(sp_val), 32'h300);
    send(OP_LDSP, 16'h03FF, 10'h0);

    // Back-pressure on the result channel
    send(OP_PUSH, 16'h5A5A, 10'h0);
    wait_ready();
    rsp_ready = 1'b0;
    sb_q.push_back('{data: 16'h5A5A, ret: 1'b0});
    send(OP_POP, 16'h0, 10'h0);
    @(negedge clk);
    for (int i = 0; i < 10 && !rsp_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_data", 32'(rsp_data), 32'h5A5A);
      chk("hold_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    wait_ready();
    chk("hold_sp", 32'(sp_val), 32'h3FF);

    // Reset while the write is in flight
    send(OP_PUSH, 16'h7777, 10'h0);
    w0 = we_cnt;
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rstw_we", 32'(mem_we), 32'd0);
    chk("rstw_dec", 32'(sp_dec), 32'd0);
    chk("rstw_ready", 32'(req_ready), 32'd1);
    chk("rstw_outs", 32'({mem_addr, mem_wdata}), 32'd0);
    chk("rstw_flags", 32'({rsp_valid, fault, mem_re, sp_inc}), 32'd0);
    chk("rstw_sp", 32'(sp_val), 32'h3FF);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstw_no_write", 32'(we_cnt - w0), 32'd0);
    chk("rstw_ram", 32'(ram[10'h3FF]), 32'h5A5A);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
